// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and limits for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_EXT = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rd_tag_t;

  localparam int TAG_W      = $bits(rd_tag_t);
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - DEPTH-stage shift register of read tags with synchronous clear
module rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [TAG_W-1:0] i_tag,
  output logic [TAG_W-1:0] o_tag
);

  logic [TAG_W-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin CPU/external arbiter for the dmem port
// with bounded external lock and tagged read-response routing.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int AW       = 6,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cpu_req,
  input  logic             i_cpu_we,
  input  logic [AW-1:0]    i_cpu_addr,
  input  logic [WIDTH-1:0] i_cpu_wdata,
  output logic             o_cpu_gnt,
  output logic             o_cpu_stall,
  output logic             o_cpu_rvalid,
  output logic [WIDTH-1:0] o_cpu_rdata,
  input  logic             i_ext_req,
  input  logic             i_ext_we,
  input  logic [AW-1:0]    i_ext_addr,
  input  logic [WIDTH-1:0] i_ext_wdata,
  input  logic             i_ext_lock,
  output logic             o_ext_gnt,
  output logic             o_ext_rvalid,
  output logic [WIDTH-1:0] o_ext_rdata,
  output logic             o_mem_en,
  output logic             o_mem_we,
  output logic [AW-1:0]    o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  input  logic [WIDTH-1:0] i_mem_rdata
);

  localparam int            LW       = $clog2(MAX_LOCK + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(MAX_LOCK);

  generate
    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
      $error("dmem_arbiter: RD_LAT must be within 1..4");
    end
  endgenerate

  req_id_e          r_last_id;
  logic [LW-1:0]    r_lock_cnt;

  logic             w_both;
  logic             w_lock_hold;
  logic             w_cpu_win;
  logic             w_ext_win;
  rd_tag_t          w_push;
  rd_tag_t          w_pop;
  logic [TAG_W-1:0] w_pop_bits;

  assign w_both      = i_cpu_req & i_ext_req;
  assign w_lock_hold = i_ext_lock && (r_last_id == REQ_EXT) && (r_lock_cnt < LOCK_MAX);

  // Contended cycles: a live lock keeps EXT, otherwise whoever did not win last time.
  always_comb begin
    w_cpu_win = 1'b0;
    w_ext_win = 1'b0;
    if (!i_reset) begin
      if (w_both) begin
        if (w_lock_hold || (r_last_id == REQ_CPU)) w_ext_win = 1'b1;
        else                                       w_cpu_win = 1'b1;
      end else begin
        w_cpu_win = i_cpu_req;
        w_ext_win = i_ext_req;
      end
    end
  end

  assign o_cpu_gnt   = w_cpu_win;
  assign o_ext_gnt   = w_ext_win;
  assign o_cpu_stall = i_cpu_req & ~w_cpu_win & ~i_reset;

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_cpu_win) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_cpu_we;
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
    end else if (w_ext_win) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_ext_we;
      o_mem_addr  = i_ext_addr;
      o_mem_wdata = i_ext_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_id  <= REQ_EXT;
      r_lock_cnt <= '0;
    end else begin
      if (w_cpu_win)      r_last_id <= REQ_CPU;
      else if (w_ext_win) r_last_id <= REQ_EXT;

      if (w_cpu_win || !i_ext_lock)
        r_lock_cnt <= '0;
      else if (w_ext_win && (r_lock_cnt < LOCK_MAX))
        r_lock_cnt <= r_lock_cnt + 1'b1;
    end
  end

  assign w_push.valid = (w_cpu_win & ~i_cpu_we) | (w_ext_win & ~i_ext_we);
  assign w_push.id    = w_ext_win ? REQ_EXT : REQ_CPU;

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .i_clk (i_clk),
    .i_clr (i_reset),
    .i_tag (w_push),
    .o_tag (w_pop_bits)
  );

  // Gate with reset so a tag still in the last stage is dropped during the reset cycle.
  assign w_pop        = rd_tag_t'(w_pop_bits);
  assign o_cpu_rvalid = w_pop.valid & ~i_reset & (w_pop.id == REQ_CPU);
  assign o_ext_rvalid = w_pop.valid & ~i_reset & (w_pop.id == REQ_EXT);
  assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : '0;
  assign o_ext_rdata  = o_ext_rvalid ? i_mem_rdata : '0;

endmodule
